iomem_button_events: RTL

Debounced, event-queued button peripheral on the PicoSoC iomem bus, one page (`PAGE`) of the peripheral address map. It sits directly upstream of the firmware's button read path and replaces raw pad sampling. Each button is synchronised and debounced, and press/release edges are converted into events. Events go into a small FIFO that firmware pops over iomem, with an optional level interrupt for the core's spare IRQ lines.

---
 rtl/iomem_button_events_pkg.sv | 32 +++
 rtl/iomem_button_events_button_debounce.sv | 54 +++++
 rtl/iomem_button_events.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/iomem_button_events_pkg.sv
// Shared register map, event field layout and event packing helper for the
// iomem button event peripheral.
package iomem_button_events_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam logic [7:0] REG_STATE  = 8'h00;
    localparam logic [7:0] REG_EVENT  = 8'h04;
    localparam logic [7:0] REG_STATUS = 8'h08;
    localparam logic [7:0] REG_IRQEN  = 8'h0C;

    localparam int EVT_VALID_BIT  = 31;
    localparam int EVT_PRESS_BIT  = 3;
    localparam int EVT_IDX_MSB    = 2;
    localparam int STATUS_OVF_BIT = 8;

    typedef struct packed {
        logic                 press;
        logic [EVT_IDX_MSB:0] idx;
    } event_t;

    // Builds the EVENT register image for a queued entry.
    function automatic logic [31:0] pack_event(input event_t e);
        logic [31:0] v;
        v                        = '0;
        v[EVT_VALID_BIT]         = 1'b1;
        v[EVT_PRESS_BIT]         = e.press;
        v[EVT_IDX_MSB:0]         = e.idx;
        return v;
    endfunction

endpackage

// File: rtl/iomem_button_events_button_debounce.sv
// One button: 2-flop synchroniser into a stability counter that commits a
// level change after DEBOUNCE_CYCLES consecutive mismatching samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_raw,
    output logic o_level,
    output logic o_toggle,
    output logic o_press
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        r_sync_meta;
    logic        r_sync;
    logic        r_state;
    logic [15:0] r_cnt;

    logic w_mismatch;
    logic w_expire;

    assign w_mismatch = r_sync ^ r_state;
    assign w_expire   = w_mismatch && (r_cnt == CNT_LAST);

    // r_state holds the raw pad polarity (1 = released) so reset means released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
            r_state     <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_sync_meta <= i_raw;
            r_sync      <= r_sync_meta;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_cnt   <= '0;
                r_state <= r_sync;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Toggle fires in the cycle before the flip so the top can latch the
    // pending flag on the same edge the debounced level changes.
    assign o_level  = ~r_state;
    assign o_toggle = w_expire;
    assign o_press  = ~r_sync;

endmodule

// File: rtl/iomem_button_events.sv
// PicoSoC iomem button peripheral: per-button debounce, press/release event
// FIFO popped by EVENT reads, status/overflow, and a registered level IRQ.
module iomem_button_events
    import iomem_button_events_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 16000,
    parameter int         FIFO_DEPTH      = 8,
    parameter logic [7:0] PAGE            = 8'h05
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  buttons_in,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_toggle;
    logic [NUM_BUTTONS-1:0] w_press;

    genvar g;
    generate
        for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .resetn  (resetn),
                .i_raw   (buttons_in[g]),
                .o_level (w_level[g]),
                .o_toggle(w_toggle[g]),
                .o_press (w_press[g])
            );
        end
    endgenerate

    logic [NUM_BUTTONS-1:0] r_pend;
    logic [NUM_BUTTONS-1:0] r_pend_press;
    event_t                 r_fifo [FIFO_DEPTH];
    logic [AW-1:0]          r_head;
    logic [AW-1:0]          r_tail;
    logic [AW:0]            r_count;
    logic                   r_ovf;
    logic                   r_irq_en;
    logic                   r_irq;
    logic                   r_ready;
    logic                   r_ack_seen;
    logic [31:0]            r_rdata;

    logic                 w_pend_any;
    logic [EVT_IDX_MSB:0] w_pick;
    event_t               w_evt;
    logic                 w_in_page;
    logic                 w_sel;
    logic                 w_is_read;
    logic [7:0]           w_offset;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_ovf_clr;
    logic [31:0]          w_rd;

    // Lowest-index pending button wins; scanning downward leaves it last.
    always_comb begin
        w_pick     = '0;
        w_pend_any = |r_pend;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_pick = 3'(i);
            end
        end
        w_evt.press = r_pend_press[w_pick];
        w_evt.idx   = w_pick;
    end

    // r_ack_seen holds off a second acknowledge until valid drops, so a
    // request held high is served (and pops) exactly once.
    assign w_in_page = (iomem_addr[31:24] == PAGE);
    assign w_sel     = iomem_valid && w_in_page && !r_ready && !r_ack_seen;
    assign w_is_read = (iomem_wstrb == 4'b0000);
    assign w_offset  = iomem_addr[7:0];
    assign w_pop     = w_sel && w_is_read && (w_offset == REG_EVENT) && (r_count != '0);
    assign w_full    = (r_count == DEPTH_CNT);
    assign w_push    = w_pend_any && (!w_full || w_pop);
    assign w_drop    = w_pend_any && w_full && !w_pop;
    assign w_ovf_clr = w_sel && (w_offset == REG_STATUS) && iomem_wstrb[1]
                       && iomem_wdata[STATUS_OVF_BIT];

    always_comb begin
        w_rd = '0;
        case (w_offset)
            REG_STATE:  w_rd[NUM_BUTTONS-1:0] = w_level;
            REG_EVENT:  if (r_count != '0) w_rd = pack_event(r_fifo[r_head]);
            REG_STATUS: begin
                w_rd[4:0]            = 5'(r_count);
                w_rd[STATUS_OVF_BIT] = r_ovf;
            end
            REG_IRQEN:  w_rd[0] = r_irq_en;
            default:    w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend       <= '0;
            r_pend_press <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (w_toggle[i]) begin
                    r_pend[i]       <= 1'b1;
                    r_pend_press[i] <= w_press[i];
                end else if (w_pend_any && (w_pick == 3'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= w_evt;
                r_tail         <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
            r_ready    <= 1'b0;
            r_ack_seen <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_sel && (w_offset == REG_IRQEN) && iomem_wstrb[0]) begin
                r_irq_en <= iomem_wdata[0];
            end
            r_irq      <= r_irq_en && (r_count != '0);
            r_ready    <= w_sel;
            r_ack_seen <= iomem_valid && (r_ack_seen || w_sel);
            r_rdata    <= (w_sel && w_is_read) ? w_rd : 32'h0;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = r_irq;

endmodule
